// File: rtl/bscan_pkg.sv
// Shared definitions for the boundary-scan TAP controller.
//   tap_state_e : the 16 IEEE 1149.1 TAP states in the conventional
//                 4-bit encoding (Test-Logic-Reset = 4'hF).
//   INSTR_*     : instruction opcodes. The values are zero-extended to
//                 IR_WIDTH at the point of use. BYPASS is all ones, and
//                 any opcode that is not listed also behaves as BYPASS.
//   IR_CAPTURE  : the two low bits loaded into the IR shift stage in
//                 Capture-IR. The upper bits are zero.
package bscan_pkg;

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

    localparam int unsigned INSTR_EXTEST = 0;
    localparam int unsigned INSTR_SAMPLE = 1;
    localparam int unsigned INSTR_IDCODE = 2;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/bscan_tap_fsm.sv
// TAP state machine: the 1149.1 next-state function and the state register.
// The state register advances only in cycles where tck_en marks a TCK
// rising edge.
// Ports:
//   clk, rst : system clock and synchronous active-high reset (reset -> TLR)
//   tck_en   : TCK rising-edge strobe
//   tms      : test mode select, sampled when tck_en=1
//   state    : current TAP state, which is also the state debug view
module bscan_tap_fsm
    import bscan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tck_en,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TLR;
        end else if (tck_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/bscan_tap_ctrl.sv
// IEEE 1149.1 TAP controller with instruction register, bypass and IDCODE
// data registers. It drives the control inputs of a DW_bc_2 boundary chain.
// TCK is modelled as a clock-enable strobe (tck_en) in the clk domain.
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   tck_en, tms, tdi   : TCK rising-edge strobe and the JTAG inputs
//   bsr_so             : serial out of the last boundary cell
//   tdo, tdo_oe        : registered test data out and its output enable
//   capture_en         : active-low capture enable to the cells
//   update_en          : update enable to the cells
//   shift_dr           : shift select to the cells
//   mode               : 1 while EXTEST drives the pins
//   capture_clk_pulse  : one-cycle capture clock enable for the cells
//   update_clk_pulse   : one-cycle update clock enable for the cells
//   dbg_state          : current TAP state (debug)
//   dbg_ir             : active instruction (debug)
module bscan_tap_ctrl
    import bscan_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck_en,
    input  logic                tms,
    input  logic                tdi,
    input  logic                bsr_so,
    output logic                tdo,
    output logic                tdo_oe,
    output logic                capture_en,
    output logic                update_en,
    output logic                shift_dr,
    output logic                mode,
    output logic                capture_clk_pulse,
    output logic                update_clk_pulse,
    output logic [3:0]          dbg_state,
    output logic [IR_WIDTH-1:0] dbg_ir
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST = IR_WIDTH'(INSTR_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(INSTR_SAMPLE);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);

    tap_state_e state;

    logic [IR_WIDTH-1:0] ir_shift;
    logic [IR_WIDTH-1:0] ir_active;
    logic                bypass_q;
    logic [31:0]         idcode_sr;

    logic is_extest;
    logic is_idcode;
    logic bsel;
    logic dr_lsb;

    bscan_tap_fsm u_fsm (
        .clk    (clk),
        .rst    (rst),
        .tck_en (tck_en),
        .tms    (tms),
        .state  (state)
    );

    // Instruction decode. Any opcode other than the three named ones
    // selects the bypass register.
    assign is_extest = (ir_active == IR_EXTEST);
    assign is_idcode = (ir_active == IR_IDCODE);
    assign bsel      = is_extest || (ir_active == IR_SAMPLE);

    always_comb begin
        dr_lsb = bypass_q;
        if (bsel) begin
            dr_lsb = bsr_so;
        end else if (is_idcode) begin
            dr_lsb = idcode_sr[0];
        end
    end

    // IR and data registers act on the TCK edge, keyed on the state in
    // which that edge occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_shift  <= '0;
            ir_active <= IR_IDCODE;
            bypass_q  <= 1'b0;
            idcode_sr <= IDCODE_VAL;
        end else begin
            if (tck_en) begin
                case (state)
                    CAP_IR: ir_shift  <= IR_CAP;
                    SH_IR:  ir_shift  <= {tdi, ir_shift[IR_WIDTH-1:1]};
                    UPD_IR: ir_active <= ir_shift;
                    CAP_DR: begin
                        bypass_q  <= 1'b0;
                        idcode_sr <= IDCODE_VAL;
                    end
                    SH_DR: begin
                        bypass_q  <= tdi;
                        idcode_sr <= {tdi, idcode_sr[31:1]};
                    end
                    default: ;
                endcase
            end
            // Test-Logic-Reset holds the active instruction at IDCODE
            // whether or not TCK is running.
            if (state == TLR) begin
                ir_active <= IR_IDCODE;
            end
        end
    end

    // Registered decodes of the current state. tdo is sampled from the
    // selected register on every clk while shifting, so it follows the
    // shift with one clk of latency and holds outside the shift states.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdo               <= 1'b0;
            tdo_oe            <= 1'b0;
            capture_en        <= 1'b1;
            update_en         <= 1'b0;
            shift_dr          <= 1'b0;
            mode              <= 1'b0;
            capture_clk_pulse <= 1'b0;
            update_clk_pulse  <= 1'b0;
        end else begin
            tdo_oe            <= (state == SH_DR) || (state == SH_IR);
            capture_en        <= !((state == CAP_DR) && bsel);
            update_en         <= (state == UPD_DR) && bsel;
            shift_dr          <= (state == SH_DR) && bsel;
            // The TLR term releases the pins in the first cycle of reset,
            // without waiting for the active IR to reload.
            mode              <= is_extest && (state != TLR);
            capture_clk_pulse <= tck_en && (state == CAP_DR) && bsel;
            update_clk_pulse  <= tck_en && (state == UPD_DR) && bsel;
            if (state == SH_IR) begin
                tdo <= ir_shift[0];
            end else if (state == SH_DR) begin
                tdo <= dr_lsb;
            end
        end
    end

    assign dbg_state = state;
    assign dbg_ir    = ir_active;

endmodule

// File: tb/tb_bscan_tap_ctrl.sv
module tb_bscan_tap_ctrl;
  import bscan_pkg::*;

  localparam int          IR_W = 4;
  localparam logic [31:0] IDC  = 32'h1BA5_E477;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tck_en = 1'b0;
  logic            tms = 1'b1;
  logic            tdi = 1'b0;
  logic            bsr_so = 1'b0;
  logic            tdo, tdo_oe, capture_en, update_en, shift_dr, mode;
  logic            capture_clk_pulse, update_clk_pulse;
  logic [3:0]      dbg_state;
  logic [IR_W-1:0] dbg_ir;

  int total = 0;
  int bad = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;
  int cap0, upd0;

  logic [31:0] exp_q[$];
  logic [IR_W-1:0] ir_cap_exp = 4'b0001;
  logic [31:0] idc_v = IDC;
  logic [3:0] pat = 4'b1011;
  logic       d;

  bscan_tap_ctrl #(.IR_WIDTH(IR_W), .IDCODE_VAL(IDC)) dut (
    .clk               (clk),
    .rst               (rst),
    .tck_en            (tck_en),
    .tms               (tms),
    .tdi               (tdi),
    .bsr_so            (bsr_so),
    .tdo               (tdo),
    .tdo_oe            (tdo_oe),
    .capture_en        (capture_en),
    .update_en         (update_en),
    .shift_dr          (shift_dr),
    .mode              (mode),
    .capture_clk_pulse (capture_clk_pulse),
    .update_clk_pulse  (update_clk_pulse),
    .dbg_state         (dbg_state),
    .dbg_ir            (dbg_ir)
  );

  // clock / reset
  always #5 clk = ~clk;

  // pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (capture_clk_pulse === 1'b1) cap_cnt++;
    if (update_clk_pulse === 1'b1) upd_cnt++;
  end

  function automatic logic [7:0] outs();
    return {tdo, tdo_oe, capture_en, update_en, shift_dr, mode,
            capture_clk_pulse, update_clk_pulse};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one TCK: strobe for one clk, then two idle clks so outputs settle
  task automatic tck(input logic tms_v, input logic tdi_v);
    @(negedge clk);
    tms = tms_v;
    tdi = tdi_v;
    tck_en = 1'b1;
    @(negedge clk);
    tck_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // RTI -> IR scan of v -> RTI; checks the capture pattern on tdo
  task automatic load_ir(input logic [IR_W-1:0] v);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) exp_q.push_back(32'(ir_cap_exp[i]));
    tck(1'b0, 1'b0);
    check("ir_tdo_oe", tdo_oe, 1);
    for (int i = 0; i < IR_W; i++) begin
      check("ir_capture_tdo", tdo, exp_q.pop_front());
      tck(i == IR_W - 1, v[i]);
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("ir_loaded", dbg_ir, v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outs", outs(), 8'b0010_0000);
    check("reset_state", dbg_state, 4'hF);
    check("reset_ir", dbg_ir, 2);

    // IDCODE read after reset
    tck(1'b0, 1'b0);
    check("rti_state", dbg_state, 4'hC);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    check("shdr_state", dbg_state, 4'h2);
    check("shdr_oe", tdo_oe, 1);
    check("shdr_no_cell_shift", shift_dr, 0);
    repeat (5) @(negedge clk);
    check("hold_no_tck", dbg_state, 4'h2);
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(idc_v[i]));
    for (int i = 0; i < 32; i++) begin
      check("idcode_tdo", tdo, exp_q.pop_front());
      tck(i == 31, 1'($urandom_range(0, 1)));
    end
    check("ex1dr_oe", tdo_oe, 0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("idcode_no_pulses", cap_cnt + upd_cnt, 0);

    // EXTEST: mode and cell controls
    load_ir(4'b0000);
    check("extest_mode", mode, 1);
    cap0 = cap_cnt;
    upd0 = upd_cnt;
    bsr_so = 1'b1;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("capdr_capture_en", capture_en, 0);
    check("capdr_no_pulse_yet", cap_cnt - cap0, 0);
    tck(1'b0, 1'b0);
    check("capture_pulse_once", cap_cnt - cap0, 1);
    check("shdr_cells", {capture_en, shift_dr}, 2'b11);
    check("tdo_bsr_hi", tdo, 1);
    bsr_so = 1'b0;
    repeat (2) @(negedge clk);
    check("tdo_bsr_lo", tdo, 0);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    check("upddr_update_en", update_en, 1);
    check("upddr_no_pulse_yet", upd_cnt - upd0, 0);
    tck(1'b0, 1'b0);
    check("update_pulse_once", upd_cnt - upd0, 1);
    check("rti_update_en", update_en, 0);

    // five tms=1 strobes from Shift-DR with EXTEST active
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    check("extest_shdr_mode", mode, 1);
    repeat (5) tck(1'b1, 1'b0);
    check("tms5_state", dbg_state, 4'hF);
    check("tms5_ir", dbg_ir, 2);
    check("tms5_mode", mode, 0);
    tck(1'b0, 1'b0);

    // BYPASS: one-strobe delay, no cell activity
    load_ir(4'b1111);
    check("bypass_mode", mode, 0);
    cap0 = cap_cnt;
    upd0 = upd_cnt;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("bypass_capture_en", capture_en, 1);
    tck(1'b0, 1'b0);
    check("bypass_shift_dr", shift_dr, 0);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      d = pat[3 - i];
      check("bypass_tdo", tdo, exp_q.pop_front());
      exp_q.push_back(32'(d));
      tck(1'b0, d);
    end
    check("bypass_tdo", tdo, exp_q.pop_front());
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    check("bypass_update_en", update_en, 0);
    tck(1'b0, 1'b0);
    check("bypass_no_pulses", (cap_cnt - cap0) + (upd_cnt - upd0), 0);

    // SAMPLE/PRELOAD: cells capture but do not drive pins
    load_ir(4'b0001);
    check("sample_mode", mode, 0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("sample_capture_en", capture_en, 0);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    check("sample_update_en", update_en, 1);
    tck(1'b0, 1'b0);

    // reset coinciding with a tck strobe during Shift-IR
    load_ir(4'b0000);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b1);
    check("pre_rst_shir", dbg_state, 4'hA);
    @(negedge clk);
    rst = 1'b1;
    tck_en = 1'b1;
    tms = 1'b1;
    tdi = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tck_en = 1'b0;
    check("rst_outs", outs(), 8'b0010_0000);
    check("rst_state", dbg_state, 4'hF);
    check("rst_ir", dbg_ir, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
